spi_shift_ctrl: RTL and testbench
=================================

# spi_shift_ctrl

Bit-level transfer engine for the SPI master, sitting directly around `spi_clkgen`. It accepts a parallel transmit word and drives `spi_clkgen` through its `en`/`st`/`last` controls. It consumes the clock generator's `pos_edge`/`neg_edge` strobes to shift MOSI and sample MISO according to CPOL/CPHA and bit order. When the transfer ends it returns the received word with a one-cycle completion pulse.

## Interface
- `DATA_WIDTH`, 32: maximum transfer length and shift register width.
- `LEN_WIDTH`, `$clog2(DATA_WIDTH)+1`: width of the length field.
---
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `en_i`  in  1  block enable; low forces IDLE (abort).
- `cpol_i`  in  1  idle SCK level.
- `cpha_i`  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- `lsb_first_i`  in  1  shift order.
- `len_i`  in  LEN_WIDTH  bits per transfer. Valid range 1..DATA_WIDTH; 0 or any value >DATA_WIDTH means DATA_WIDTH.
- `start_i`  in  1  single-cycle request, accepted only in IDLE.
- `tx_data_i`  in  DATA_WIDTH  word to send, right-aligned.
- `pos_edge_i`, `neg_edge_i`  in  1  SCK edge strobes from `spi_clkgen`.
- `miso_i`  in  1  serial input, already synchronised.
- `clk_en_o`  out  1  to clkgen `en_i`.
- `st_o`  out  1  to clkgen `st_i`; one-cycle pulse on accept.
- `last_o`  out  1  to clkgen `last_i`.
- `mosi_o`  out  1  serial output.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `rx_data_o`  out  DATA_WIDTH  received word, right-aligned; held until the next done.

## Operation
- Edge decode:
  - `lead = cpol_i ? neg_edge_i : pos_edge_i`; `trail` is the other strobe.
  - `sample = cpha_i ? trail : lead`; `shift = cpha_i ? lead : trail`.
- States: IDLE, XFER, TAIL.
- IDLE → XFER on `start_i & en_i`. In the same edge:
  - load the shift register from `tx_data_i`;
  - set `bit_cnt = eff_len`;
  - pulse `st_o`.
  - With CPHA=0, `mosi_o` takes the first bit immediately: bit `eff_len-1`, or bit 0 when `lsb_first_i` is set.
- XFER:
  - `clk_en_o` = 1.
  - On `shift`: advance the shift register and drive the next bit onto `mosi_o`. With CPHA=1 the first `shift` presents the first bit. Any `shift` after the final sample is ignored.
  - On `sample`: insert `miso_i` into the receive register and decrement `bit_cnt`.
- `last_o` is high while `bit_cnt == 1`, and stays high in TAIL.
- Final sample (`bit_cnt` 1→0):
  - CPHA=1: SCK is already idle. Go to IDLE, pulse `done_o`, update `rx_data_o`.
  - CPHA=0: go to TAIL and wait for one `trail` edge, then do the same as CPHA=1.
- The receive register is right-aligned for every `eff_len`. In MSB-first mode it shifts left and inserts at bit 0. In LSB-first mode it inserts at bit `eff_len-1` and shifts right.
- Unused upper bits of `rx_data_o` are 0.
- `start_i` while busy is ignored.
- `en_i` low in any state:
  - next state IDLE; `clk_en_o`, `last_o` and `busy_o` low;
  - no `done_o`; `rx_data_o` unchanged.
- `cpol_i`, `cpha_i`, `lsb_first_i` and `len_i` must be stable while busy. The block does not capture `cpol_i`/`cpha_i`/`lsb_first_i`; it captures `len_i` as `eff_len` on accept.

## Timing
- Reset values: state IDLE; all outputs 0, including `mosi_o` and `rx_data_o`.
- `st_o` and `clk_en_o` rise in the cycle after `start_i` is sampled.
- `done_o` and the new `rx_data_o` appear in the cycle after the terminating edge strobe. `busy_o` falls in that same cycle.
- A new `start_i` is accepted in the cycle where `done_o` is high.
- `mosi_o` changes only in the cycle after a `shift` strobe, or on accept.
- A `pos_edge_i`/`neg_edge_i` strobe is at most one cycle wide. If both are asserted in the same cycle, the sample action is applied before the shift action.
- Reset asserted mid-transfer forces the reset values immediately, asynchronously.

## Structure
- Shared `spi_define` package holds:
  - the state enum `spi_xfer_state_e`;
  - `SPI_DATA_WIDTH`;
  - `SPI_LEN_WIDTH`.
- Natural sub-module: `spi_bitcnt`, a loadable down-counter with zero/one flags. It is reusable by a future slave-side engine.
- Edge decode and both shift registers stay in the top level.

## Test plan
- CPOL=0, CPHA=0, MSB-first, len=8, tx=0xA5, MISO looped to MOSI → MOSI sequence 1,0,1,0,0,1,0,1; `rx_data_o`=0xA5; exactly 8 pos strobes before `done_o`.
- CPOL=1, CPHA=1, LSB-first, len=8, tx=0x3C, MISO driven with pattern 0x81 → MOSI sequence 0,0,1,1,1,1,0,0; `rx_data_o`=0x81; SCK idles high at done.
- Divide-by-2 (`clk_div`=0) with len=32, tx=0xDEADBEEF in loopback → `rx_data_o`=0xDEADBEEF; `last_o` high exactly during the final bit and TAIL.
- len=1 and len=0 (treated as 32) in all four modes → one and 32 sample edges respectively; `done_o` pulses once.
- `en_i` dropped after bit 3 of 8 → busy/clk_en low next cycle; no `done_o`; `rx_data_o` unchanged; next start completes normally.
- `start_i` held for 3 cycles, then reasserted in the `done_o` cycle → exactly two transfers, back to back.

Source files
------------

// File: rtl/spi_define.sv
// spi_define: shared widths and transfer-state encoding for the SPI master engines.
package spi_define;
    localparam int SPI_DATA_WIDTH = 32;
    localparam int SPI_LEN_WIDTH  = $clog2(SPI_DATA_WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, XFER, TAIL} spi_xfer_state_e;
endpackage

// File: rtl/spi_bitcnt.sv
// spi_bitcnt: loadable down-counter with zero/one flags; holds at zero.
module spi_bitcnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         zero,
    output logic         one
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
    assign one  = cnt == W'(1);
endmodule

// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: SPI master bit engine; drives spi_clkgen controls and shifts
// MOSI/MISO on its edge strobes according to CPOL/CPHA and bit order.
module spi_shift_ctrl
    import spi_define::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_first_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  pos_edge_i,
    input  logic                  neg_edge_i,
    input  logic                  miso_i,
    output logic                  clk_en_o,
    output logic                  st_o,
    output logic                  last_o,
    output logic                  mosi_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rx_data_o
);
    spi_xfer_state_e state;
    logic lead, trail, sample, shift;
    logic accept, do_sample, final_s, do_shift, finish, zero, one;
    logic [LEN_WIDTH-1:0] eff_len, len_q;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, aligned, rx_next;

    function automatic logic head(input logic lsb, input logic [DATA_WIDTH-1:0] v);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] adv(input logic lsb, input logic [DATA_WIDTH-1:0] v);
        return lsb ? v >> 1 : v << 1;
    endfunction

    assign lead   = cpol_i ? neg_edge_i : pos_edge_i;
    assign trail  = cpol_i ? pos_edge_i : neg_edge_i;
    assign sample = cpha_i ? trail : lead;
    assign shift  = cpha_i ? lead : trail;

    assign eff_len = (len_i == '0 || len_i > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : len_i;

    assign accept    = state == IDLE && start_i && en_i;
    assign do_sample = state == XFER && en_i && sample && !zero;
    assign final_s   = do_sample && one;
    assign do_shift  = state == XFER && en_i && shift && !final_s;
    assign finish    = (final_s && cpha_i) || (state == TAIL && en_i && trail);

    // MSB-first words are left-aligned so the first bit always sits at the top
    assign aligned = lsb_first_i ? tx_data_i : tx_data_i << (LEN_WIDTH'(DATA_WIDTH) - eff_len);
    assign rx_next = lsb_first_i ? (rx_sr >> 1) | (DATA_WIDTH'(miso_i) << (len_q - 1'b1))
                                 : {rx_sr[DATA_WIDTH-2:0], miso_i};

    assign busy_o   = state != IDLE;
    assign clk_en_o = busy_o;
    assign last_o   = state == TAIL || (state == XFER && one);

    spi_bitcnt #(.W(LEN_WIDTH)) u_bitcnt (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (accept),
        .dec  (do_sample),
        .val  (eff_len),
        .zero (zero),
        .one  (one)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            len_q     <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_o <= '0;
            mosi_o    <= 1'b0;
            st_o      <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            st_o   <= accept;
            done_o <= finish;
            if (accept) begin
                state <= XFER;
                len_q <= eff_len;
                rx_sr <= '0;
                tx_sr <= cpha_i ? aligned : adv(lsb_first_i, aligned);
                if (!cpha_i) mosi_o <= head(lsb_first_i, aligned);
            end
            if (do_sample) rx_sr <= rx_next;
            if (do_shift) begin
                mosi_o <= head(lsb_first_i, tx_sr);
                tx_sr  <= adv(lsb_first_i, tx_sr);
            end
            if (final_s) state <= cpha_i ? IDLE : TAIL;
            if (finish) begin
                state     <= IDLE;
                rx_data_o <= cpha_i ? rx_next : rx_sr;
            end
            if (!en_i) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: randomized transfers against a word-level model with an
// SCK strobe generator standing in for spi_clkgen.
module tb_spi_shift_ctrl;
    logic        clk_i = 0, rst_i, en_i, cpol_i, cpha_i, lsb_first_i, start_i;
    logic [5:0]  len_i;
    logic [31:0] tx_data_i, rx_data_o;
    logic        pos_edge_i, neg_edge_i, miso_i;
    logic        clk_en_o, st_o, last_o, mosi_o, busy_o, done_o;
    int          tests = 0, fails = 0;
    logic [31:0] last_rx = 0;
    logic [31:0] m;

    spi_shift_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .lsb_first_i(lsb_first_i), .len_i(len_i), .start_i(start_i), .tx_data_i(tx_data_i),
        .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i), .miso_i(miso_i),
        .clk_en_o(clk_en_o), .st_o(st_o), .last_o(last_o), .mosi_o(mosi_o),
        .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One transfer from the current negedge; returns in the done cycle (or after abort).
    task automatic xfer(input bit cpol, input bit cpha, input bit lsb, input logic [5:0] len,
                        input logic [31:0] tx, input bit loop, input logic [31:0] pat,
                        input int div, input int hold, input int abort_at, output logic [31:0] mseq);
        int n, s, leads, ph, cyc, sts, hl;
        bit sck, fin, p_smp, p_fin, ed, is_lead;
        logic [31:0] exp_rx;
        n = (len == 0 || len > 32) ? 32 : int'(len);
        exp_rx = loop ? tx : pat;
        if (n < 32) exp_rx = exp_rx & ((32'd1 << n) - 1);
        s = 0; leads = 0; ph = 0; cyc = 0; sts = 0; hl = hold;
        sck = cpol; fin = 0; p_smp = 0; p_fin = 0; mseq = 0;
        cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb; len_i = len; tx_data_i = tx;
        start_i = 1; pos_edge_i = 0; neg_edge_i = 0;
        while (!fin) begin
            @(negedge clk_i);
            cyc++;
            if (p_smp) s++;
            ed = p_fin;
            if (st_o) sts++;
            chk("done", done_o, ed);
            chk("busy", busy_o, !ed);
            chk("clk_en", clk_en_o, !ed);
            chk("last", last_o, !ed && s >= n - 1);
            hl--;
            start_i = hl > 0;
            pos_edge_i = 0; neg_edge_i = 0; p_smp = 0; p_fin = 0;
            if (ed) begin
                fin = 1;
                chk("rx_data", rx_data_o, exp_rx);
                chk("lead_edges", leads, n);
                chk("st_pulses", sts, 1);
                chk("sck_idle", sck, cpol);
                last_rx = exp_rx;
            end else if (abort_at > 0 && s == abort_at) begin
                en_i = 0; start_i = 0;
                @(negedge clk_i);
                chk("abort_busy", busy_o, 0);
                chk("abort_clk_en", clk_en_o, 0);
                chk("abort_last", last_o, 0);
                chk("abort_done", done_o, 0);
                chk("abort_rx", rx_data_o, last_rx);
                en_i = 1; fin = 1;
            end else if (cyc > 3000) begin
                tests++; fails++;
                $display("FAIL timeout: no done after %0d cycles", cyc);
                start_i = 0; fin = 1;
            end else if (ph == div) begin
                ph = 0; sck = !sck; is_lead = sck != cpol;
                pos_edge_i = sck; neg_edge_i = !sck;
                if (is_lead) leads++;
                if (is_lead != cpha) begin
                    chk("mosi", mosi_o, lsb ? tx[s] : tx[n-1-s]);
                    mseq = {mseq[30:0], mosi_o};
                    miso_i = loop ? mosi_o : (lsb ? pat[s] : pat[n-1-s]);
                    p_smp = 1;
                    p_fin = cpha && s == n - 1;
                end else p_fin = !cpha && s == n;
            end else ph++;
        end
    endtask

    initial begin
        rst_i = 1; en_i = 1; cpol_i = 0; cpha_i = 0; lsb_first_i = 0; start_i = 0;
        len_i = 0; tx_data_i = 0; pos_edge_i = 0; neg_edge_i = 0; miso_i = 0;
        repeat (3) @(negedge clk_i);
        chk("reset_ctrl", {busy_o, clk_en_o, last_o, st_o, done_o, mosi_o}, 0);
        chk("reset_rx", rx_data_o, 0);
        rst_i = 0;
        @(negedge clk_i);
        chk("idle_ctrl", {busy_o, clk_en_o, last_o, st_o, done_o, mosi_o}, 0);

        xfer(0, 0, 0, 8, 32'hA5, 1, 0, 1, 1, 0, m);
        chk("t1_mosi_seq", m, 32'hA5);
        chk("t1_rx", rx_data_o, 32'hA5);
        @(negedge clk_i);
        xfer(1, 1, 1, 8, 32'h3C, 0, 32'h81, 1, 1, 0, m);
        chk("t2_mosi_seq", m, 32'h3C);
        chk("t2_rx", rx_data_o, 32'h81);
        xfer(0, 0, 0, 32, 32'hDEADBEEF, 1, 0, 0, 1, 0, m);
        chk("t3_rx", rx_data_o, 32'hDEADBEEF);

        for (int md = 0; md < 4; md++) begin
            xfer(md[1], md[0], 1'($urandom), 1, $urandom, 0, $urandom, $urandom_range(0, 2), 1, 0, m);
            xfer(md[1], md[0], 1'($urandom), 0, $urandom, 1, 0, $urandom_range(0, 2), 1, 0, m);
        end
        @(negedge clk_i);
        chk("len0_done_once", done_o, 0);

        xfer(0, 1, 0, 8, $urandom, 0, $urandom, 1, 1, 3, m);
        xfer(0, 1, 0, 8, 32'h5A, 1, 0, 1, 1, 0, m);
        chk("post_abort_rx", rx_data_o, 32'h5A);

        xfer(1, 0, 0, 8, 32'hC3, 1, 0, 1, 3, 0, m);
        xfer(1, 0, 1, 8, 32'h96, 0, 32'h17, 1, 1, 0, m);
        chk("b2b_rx", rx_data_o, 32'h17);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), $urandom, 1'($urandom),
                 $urandom, $urandom_range(0, 3), $urandom_range(1, 3), 0, m);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end

        @(negedge clk_i);
        cpol_i = 0; cpha_i = 0; lsb_first_i = 0; len_i = 8; tx_data_i = 32'h80; start_i = 1;
        @(negedge clk_i);
        start_i = 0; pos_edge_i = 1;
        @(negedge clk_i);
        pos_edge_i = 0;
        #2 rst_i = 1;
        #1;
        chk("async_rst_ctrl", {busy_o, clk_en_o, last_o, st_o, done_o, mosi_o}, 0);
        chk("async_rst_rx", rx_data_o, 0);
        @(negedge clk_i);
        rst_i = 0; last_rx = 0;
        @(negedge clk_i);
        xfer(1, 1, 0, 12, 32'hABC, 1, 0, 2, 1, 0, m);
        chk("post_rst_rx", rx_data_o, 32'hABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
